// File: rtl/seq_rcv.sv
// seq_rcv: serial sequence receiver.
// Reassembles 8-slot frames (data in slots 0..WIDTH-1, LSB first, zero guard
// slots after) into WIDTH-bit words, compares each word against TARGET,
// counts matches with saturation, and declares lock after three consecutive
// matching frames.
module seq_rcv #(
  parameter int WIDTH = 6,
  parameter int FRAME = 8,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             X,
  input  logic             SYNC,
  input  logic [WIDTH-1:0] TARGET,
  output logic [WIDTH-1:0] DATA,
  output logic             VALID,
  output logic             MATCH,
  output logic [CNT_W-1:0] MATCH_CNT,
  output logic             LOCKED,
  output logic             ERR,
  output logic [2:0]       SLOT,
  output logic [WIDTH-1:0] LEDS
);

  localparam logic [2:0]       SLOT_LAST  = 3'(WIDTH - 1);
  localparam logic [2:0]       SLOT_GUARD = 3'(WIDTH);
  localparam logic [2:0]       SLOT_END   = 3'(FRAME - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_M1     = 2'd1,
    ST_M2     = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  logic [2:0]       r_cnt;
  // The top data bit is never stored: it is taken straight from X at commit.
  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_match;
  logic [CNT_W-1:0] r_match_cnt;
  logic             r_locked;
  logic             r_err;
  state_t           r_state;

  logic             w_commit;
  logic             w_guard;
  logic [WIDTH-1:0] w_word;
  logic             w_match;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_leds;

  // SYNC forces slot 0, so it suppresses a commit that would land on this edge.
  assign w_commit = !SYNC && (r_cnt == SLOT_LAST);
  assign w_guard  = !SYNC && (r_cnt >= SLOT_GUARD);
  assign w_word   = {X, r_shift};
  assign w_match  = (w_word == TARGET);

  // Slot counter: free-running modulo FRAME, realigned to slot 1 after a SYNC cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= 3'd0;
    end else if (SYNC) begin
      r_cnt <= 3'd1;
    end else if (r_cnt == SLOT_END) begin
      r_cnt <= 3'd0;
    end else begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  // Shift register: SYNC restarts the word with bit 0, otherwise store X in bit [cnt].
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shift <= '0;
    end else if (SYNC) begin
      r_shift <= {{(WIDTH-2){1'b0}}, X};
    end else begin
      for (int i = 0; i < WIDTH - 1; i++) begin
        if (r_cnt == 3'(i)) begin
          r_shift[i] <= X;
        end
      end
    end
  end

  // Commit stage: latch the word, match flag and saturating match count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_match     <= 1'b0;
      r_match_cnt <= '0;
    end else if (w_commit) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
      r_match <= w_match;
      if (w_match && (r_match_cnt != CNT_MAX)) begin
        r_match_cnt <= r_match_cnt + CNT_ONE;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  // Sticky framing error: set by a 1 in a guard slot, cleared only by SYNC.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_err <= 1'b0;
    end else if (SYNC) begin
      r_err <= 1'b0;
    end else if (w_guard && X) begin
      r_err <= 1'b1;
    end
  end

  // Lock FSM state register and its registered LOCKED flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ST_SEARCH;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
    end
  end

  // Lock FSM next state: advance on a matching commit, fall back on a mismatch.
  always_comb begin
    w_state_nxt = r_state;
    if (w_commit) begin
      if (w_match) begin
        case (r_state)
          ST_SEARCH: w_state_nxt = ST_M1;
          ST_M1:     w_state_nxt = ST_M2;
          ST_M2:     w_state_nxt = ST_LOCKED;
          ST_LOCKED: w_state_nxt = ST_LOCKED;
          default:   w_state_nxt = ST_SEARCH;
        endcase
      end else begin
        w_state_nxt = ST_SEARCH;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Slot indicator: one-hot of the slot during data slots, dark in guard slots.
  always_comb begin
    w_leds = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_cnt == 3'(i)) begin
        w_leds[i] = 1'b1;
      end else begin
        w_leds[i] = 1'b0;
      end
    end
  end

  assign DATA      = r_data;
  assign VALID     = r_valid;
  assign MATCH     = r_match;
  assign MATCH_CNT = r_match_cnt;
  assign LOCKED    = r_locked;
  assign ERR       = r_err;
  assign SLOT      = r_cnt;
  assign LEDS      = w_leds;

endmodule

// File: doc/seq_rcv.md
# seq_rcv

Serial sequence receiver: the far end of the switch-sequence serializer. It samples a one-bit-per-clock stream in which each 8-slot frame carries data bits in slots 0–5, least-significant first, and zeros in guard slots 6–7. It reassembles each frame into a 6-bit word, compares the word against a target pattern, counts matches, and runs a lock state machine that declares lock after three consecutive matching frames. It sits between the serial link (X) and board LEDs / display logic.

## Interface
- WIDTH, 6, data bits per frame; slots 0..WIDTH-1 carry data.
- FRAME, 8, slots per frame; the slot counter is 3 bits and must satisfy FRAME > WIDTH.
- CNT_W, 8, width of MATCH_CNT.

Ports:
- CLK  in  1  rising-edge clock (one clock only).
- RST_N  in  1  asynchronous, active-low reset.
- X  in  1  serial data bit for the current slot.
- SYNC  in  1  when high, the current cycle is slot 0; realigns the slot counter.
- TARGET  in  WIDTH  pattern compared at each commit.
- DATA  out  WIDTH  last committed word; bit i came from slot i.
- VALID  out  1  one-cycle pulse when DATA has just been committed.
- MATCH  out  1  last committed word equalled TARGET; held until the next commit.
- MATCH_CNT  out  CNT_W  number of matching commits; saturates at all-ones.
- LOCKED  out  1  high in LOCKED state.
- ERR  out  1  sticky framing error (guard-slot bit was 1).
- SLOT  out  3  current slot counter.
- LEDS  out  WIDTH  one-hot of SLOT when SLOT<WIDTH, else 0 (combinational from SLOT).

## Operation
- Slot counter `cnt` increments by 1 each clock and wraps from FRAME-1 to 0.
- If SYNC=1, the cycle is treated as slot 0: bit 0 is captured from X and cnt<=1. Any partial word is discarded, and no commit occurs in that cycle even if cnt==WIDTH-1.
- Otherwise, when cnt<WIDTH, X is stored into shift bit [cnt].
- Commit at the edge where cnt==WIDTH-1 and SYNC=0:
  - DATA <= {X, shift[WIDTH-2:0]}; VALID <= 1.
  - MATCH <= (that word == TARGET). TARGET is sampled at this edge only.
  - If the word matches, MATCH_CNT increments unless it is already all-ones.
  - The FSM steps.
- VALID is 0 at every other edge.
- Guard slots (cnt>=WIDTH, SYNC=0): if X=1, ERR <= 1. ERR is cleared only by reset or by SYNC; if SYNC and a guard violation coincide, SYNC wins and ERR is cleared.
- Lock FSM (steps only at commit): states SEARCH, M1, M2, LOCKED.
  - On match: SEARCH→M1→M2→LOCKED; LOCKED stays LOCKED.
  - On mismatch: any state→SEARCH.
  - LOCKED output = (state==LOCKED), registered.
- SYNC does not change the FSM state, MATCH, or MATCH_CNT.

## Timing
- Reset values (asynchronous, immediate): cnt=0, shift=0, DATA=0, VALID=0, MATCH=0, MATCH_CNT=0, LOCKED=0 (state SEARCH), ERR=0. LEDS therefore shows 000001 during and after reset.
- Reset mid-frame discards the partial word. The first edge after release samples slot 0.
- Latency: the slot-5 bit sampled at edge N appears on DATA, VALID, MATCH, MATCH_CNT and LOCKED after edge N, all in the same cycle.
- Free-running commit period is FRAME cycles. After a SYNC at edge S, the next commit is at edge S+WIDTH-1.
- LOCKED rises after the third consecutive matching commit and falls after the first mismatching commit.
- MATCH_CNT stays at all-ones on further matches and does not wrap.

## Test plan
- Reset, then drive X=1,0,1,1,0,1,0,0 for slots 0–7 with TARGET=101101 → VALID pulses once after the 6th edge, DATA=101101, MATCH=1, MATCH_CNT=1, LOCKED=0.
- Repeat that frame 3 times → LOCKED=1 after the 3rd VALID, MATCH_CNT=3. A 4th frame with DATA=000001 → MATCH=0, LOCKED=0, MATCH_CNT holds at 3.
- Assert SYNC at slot 3 mid-frame → no VALID for the aborted frame, SLOT=1 after the SYNC edge, next VALID 5 edges after the SYNC edge, and DATA reflects only post-SYNC bits.
- Drive X=1 in slot 6 → ERR=1 and stays 1 across later clean frames; a SYNC pulse → ERR=0.
- Preload 254 matches (TARGET=000000, X=0), then 3 more matching frames → MATCH_CNT=255 and stays 255.
- Assert RST_N=0 asynchronously between edges at slot 4 → all outputs go to reset values immediately; after release, a clean frame commits correctly with LOCKED=0 until three matches.
